truth_table_scanner: RTL and testbench

- Sequential counterpart to the team's four-input combinational logic blocks.
- Those blocks map inputs A..D to a single output Y. This block goes the other way: it drives all 16 input combinations into an external combinational function, samples the returned Y, and rebuilds the 16-bit truth table.
- Also reports the minterm count and the lowest minterm index.
- Sits beside the gate-level block under test on the lab board, or in a self-checking bench wrapper.

---
 rtl/truth_table_scanner.sv | 155 +++++++++++++++
 tb/tb_truth_table_scanner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks all 16 {A,B,C,D} combinations through an external
// four-input combinational function, samples its Y after a settle window, and
// rebuilds the truth table. It also reports the minterm count and the lowest
// minterm index.
module truth_table_scanner #(
  parameter int SETTLE = 2  // wait cycles per vector before Y is sampled (0..15)
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic        iAbort,
  input  logic        iY,
  output logic        oA,
  output logic        oB,
  output logic        oC,
  output logic        oD,
  output logic        oBusy,
  output logic        oDone,
  output logic [15:0] oTable,
  output logic [4:0]  oOnes,
  output logic [3:0]  oMinIdx,
  output logic        oNone
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_idx;
  logic [3:0]  r_cnt;
  logic [3:0]  r_vec;
  logic [15:0] r_table;
  logic [4:0]  r_ones;
  logic [3:0]  r_min_idx;
  logic        r_none;
  logic        r_busy;
  logic        r_done;

  logic w_start;
  logic w_abort;
  logic w_sample;
  logic w_last;

  // Next-state decode plus the one-hot events that steer the datapath.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    w_next   = r_state;
    w_start  = 1'b0;
    w_abort  = 1'b0;
    w_sample = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iStart) begin
          w_start = 1'b1;
          w_next  = S_RUN;
        end
      end
      S_RUN: begin
        if (iAbort) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (r_cnt == SETTLE_CNT) begin
          w_sample = 1'b1;
          if (r_idx == 4'hF) begin
            w_last = 1'b1;
            w_next = S_DONE;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (iRst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Vector index, settle counter and the registered drive to A..D.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_idx <= 4'd0;
      r_cnt <= 4'd0;
      r_vec <= 4'd0;
    end else if (w_start || w_abort) begin
      r_idx <= 4'd0;
      r_cnt <= 4'd0;
      r_vec <= 4'd0;
    end else if (w_sample) begin
      r_cnt <= 4'd0;
      if (w_last) begin
        r_vec <= 4'd0;            // idx stays at 15; drive returns to 0 in DONE
      end else begin
        r_idx <= r_idx + 4'd1;
        r_vec <= r_idx + 4'd1;
      end
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Result accumulation: table bit, minterm count and first minterm seen.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_table   <= 16'h0000;
      r_ones    <= 5'd0;
      r_min_idx <= 4'd0;
      r_none    <= 1'b1;
    end else if (w_start || w_abort) begin
      r_table   <= 16'h0000;
      r_ones    <= 5'd0;
      r_min_idx <= 4'd0;
      r_none    <= 1'b1;
    end else if (w_sample) begin
      r_table[r_idx] <= iY;
      r_ones         <= r_ones + {4'd0, iY};
      if (iY && r_none) begin
        r_min_idx <= r_idx;
        r_none    <= 1'b0;
      end
    end
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next == S_RUN);
      r_done <= (w_next == S_DONE);
    end
  end

  assign {oA, oB, oC, oD} = r_vec;
  assign oBusy            = r_busy;
  assign oDone            = r_done;
  assign oTable           = r_table;
  assign oOnes            = r_ones;
  assign oMinIdx          = r_min_idx;
  assign oNone            = r_none;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: directed stub functions drive iY, a scoreboard
// queue holds expected results per scan, and a monitor checks results on oDone
// and the per-vector hold timing.
module tb_truth_table_scanner;

  localparam int SETTLE = 2;
  localparam int SCAN   = 16 * (SETTLE + 1);

  typedef enum int {M_AB, M_PAR, M_ONE, M_ZERO, M_NINE} mode_t;

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  ones;
    logic [3:0]  min_idx;
    logic        none;
    int          done_cyc;
  } exp_t;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iStart;
  logic        iAbort;
  logic        iY;
  logic        oA, oB, oC, oD;
  logic        oBusy, oDone, oNone;
  logic [15:0] oTable;
  logic [4:0]  oOnes;
  logic [3:0]  oMinIdx;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    age      = 100;
  int    hold_len = 0;
  mode_t mode     = M_ZERO;
  logic  glitch   = 1'b0;
  logic  timing_en = 1'b1;
  logic [3:0] prev_vec  = 4'd0;
  logic       prev_busy = 1'b0;
  exp_t  sb_q[$];

  truth_table_scanner #(.SETTLE(SETTLE)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iAbort(iAbort), .iY(iY),
    .oA(oA), .oB(oB), .oC(oC), .oD(oD), .oBusy(oBusy), .oDone(oDone),
    .oTable(oTable), .oOnes(oOnes), .oMinIdx(oMinIdx), .oNone(oNone)
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  function automatic logic stub(input mode_t m, input logic [3:0] v);
    case (m)
      M_AB:    return v[3] & v[2];
      M_PAR:   return ^v;
      M_ONE:   return 1'b1;
      M_NINE:  return (v == 4'd9);
      default: return 1'b0;
    endcase
  endfunction

  // Function under test; optionally wrong during the first SETTLE cycles of a vector.
  assign iY = stub(mode, {oA, oB, oC, oD}) ^ (glitch && oBusy && (age < SETTLE));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor and per-vector timing monitor.
  always @(negedge iClk) begin
    logic [3:0] vec;
    exp_t e;
    vec = {oA, oB, oC, oD};
    if (oDone) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("table",    32'(oTable),  32'(e.tbl));
        check("ones",     32'(oOnes),   32'(e.ones));
        check("min_idx",  32'(oMinIdx), 32'(e.min_idx));
        check("none",     32'(oNone),   32'(e.none));
        check("done_cyc", 32'(cyc),     32'(e.done_cyc));
        check("busy_in_done", 32'(oBusy), 32'd0);
      end
    end
    if (oBusy) begin
      if (!prev_busy) begin
        if (timing_en) check("first_vec", 32'(vec), 32'd0);
        hold_len = 1;
      end else if (vec != prev_vec) begin
        if (timing_en) begin
          check("hold_len",  32'(hold_len), 32'(SETTLE + 1));
          check("vec_order", 32'(vec), 32'(prev_vec + 4'd1));
        end
        hold_len = 1;
      end else begin
        hold_len++;
      end
    end else if (prev_busy && oDone && timing_en) begin
      check("hold_len_last", 32'(hold_len), 32'(SETTLE + 1));
      check("last_vec",      32'(prev_vec), 32'd15);
    end
    if ((vec != prev_vec) || (oBusy && !prev_busy)) age = 0;
    else if (age < 100) age++;
    prev_vec  = vec;
    prev_busy = oBusy;
  end

  function automatic exp_t mk(input logic [15:0] t, input logic [4:0] o,
                              input logic [3:0] m, input logic n, input int d);
    exp_t e;
    e.tbl = t; e.ones = o; e.min_idx = m; e.none = n; e.done_cyc = d;
    return e;
  endfunction

  // Push the expectation, then pulse iStart for one cycle.
  task automatic start_scan(input logic [15:0] t, input logic [4:0] o,
                            input logic [3:0] m, input logic n);
    sb_q.push_back(mk(t, o, m, n, cyc + 1 + SCAN));
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge iClk);
    check("drain_timeout", 32'(sb_q.size()), 32'd0);
    repeat (3) @(negedge iClk);
  endtask

  task automatic wait_vec(input logic [3:0] v);
    for (int i = 0; i < 200 && {oA, oB, oC, oD} != v; i++) @(negedge iClk);
    check("wait_vec", 32'({oA, oB, oC, oD}), 32'(v));
  endtask

  task automatic check_idle_clear(input string tag);
    check({tag, "_vec"},   32'({oA, oB, oC, oD}), 32'd0);
    check({tag, "_busy"},  32'(oBusy),   32'd0);
    check({tag, "_done"},  32'(oDone),   32'd0);
    check({tag, "_table"}, 32'(oTable),  32'h0);
    check({tag, "_ones"},  32'(oOnes),   32'd0);
    check({tag, "_min"},   32'(oMinIdx), 32'd0);
    check({tag, "_none"},  32'(oNone),   32'd1);
  endtask

  initial begin
    int base;
    iRst = 1'b1; iStart = 1'b0; iAbort = 1'b0;
    repeat (2) @(negedge iClk);
    check_idle_clear("reset");
    iRst = 1'b0;
    repeat (2) @(negedge iClk);

    // Basic patterns.
    mode = M_AB;   start_scan(16'hF000, 5'd4,  4'd12, 1'b0); drain();
    mode = M_PAR;  start_scan(16'h6996, 5'd8,  4'd1,  1'b0); drain();
    mode = M_ONE;  start_scan(16'hFFFF, 5'd16, 4'd0,  1'b0); drain();
    mode = M_ZERO; start_scan(16'h0000, 5'd0,  4'd0,  1'b1); drain();
    mode = M_NINE; start_scan(16'h0200, 5'd1,  4'd9,  1'b0); drain();

    // Y glitches during the settle window must not reach the table.
    glitch = 1'b1;
    mode = M_PAR;  start_scan(16'h6996, 5'd8,  4'd1,  1'b0); drain();
    mode = M_AB;   start_scan(16'hF000, 5'd4,  4'd12, 1'b0); drain();
    glitch = 1'b0;

    // Abort at idx 7: partial results cleared, no oDone.
    timing_en = 1'b0;
    mode = M_ONE;
    iStart = 1'b1; @(negedge iClk); iStart = 1'b0;
    wait_vec(4'd7);
    check("pre_abort_table", 32'(oTable), 32'h007F);
    iAbort = 1'b1; @(negedge iClk); iAbort = 1'b0;
    check_idle_clear("abort");
    repeat (SCAN + 10) @(negedge iClk);
    check("abort_no_done_q", 32'(sb_q.size()), 32'd0);

    // Abort in IDLE together with start: start wins.
    timing_en = 1'b1;
    iAbort = 1'b1;
    mode = M_NINE; start_scan(16'h0200, 5'd1, 4'd9, 1'b0);
    iAbort = 1'b0;
    drain();

    // Asynchronous reset at idx 5: outputs clear without a clock edge.
    timing_en = 1'b0;
    mode = M_PAR;
    iStart = 1'b1; @(negedge iClk); iStart = 1'b0;
    wait_vec(4'd5);
    check("pre_reset_table", 32'(oTable), 32'h0016);
    #1 iRst = 1'b1;
    #1 check_idle_clear("async_rst");
    @(negedge iClk); iRst = 1'b0;
    repeat (2) @(negedge iClk);
    timing_en = 1'b1;
    mode = M_AB; start_scan(16'hF000, 5'd4, 4'd12, 1'b0); drain();

    // iStart during RUN is ignored; done timing unchanged.
    mode = M_PAR; start_scan(16'h6996, 5'd8, 4'd1, 1'b0);
    repeat (10) @(negedge iClk);
    iStart = 1'b1; @(negedge iClk); iStart = 1'b0;
    drain();

    // iStart held high: back-to-back scans, second starts on first IDLE cycle.
    mode = M_ONE;
    base = cyc;
    sb_q.push_back(mk(16'hFFFF, 5'd16, 4'd0, 1'b0, base + 1 + SCAN));
    sb_q.push_back(mk(16'hFFFF, 5'd16, 4'd0, 1'b0, base + 1 + SCAN + 2 + SCAN));
    iStart = 1'b1;
    for (int i = 0; i < 200 && cyc < base + 1 + SCAN + 2; i++) @(negedge iClk);
    iStart = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
